// File: rtl/rs_result_axis_packer.sv
// rs_result_axis_packer: serializes decoded RS packets into 3-beat
// 64-bit AXI-Stream packets, one zero-extended symbol per byte.
// Ports: pkt_* decoder input (no backpressure), m_axis_* stream out,
// pkt_drop/drop_cnt overflow reporting, busy while any slot is held.
module rs_result_axis_packer #(
  parameter int SYM_BITS = 5,
  parameter int N_SYM    = 21,
  parameter int ERR_BITS = 3,
  parameter int CNT_BITS = 8
) (
  input  logic                      m_axis_aclk,
  input  logic                      m_axis_aresetn,
  input  logic                      pkt_vld,
  input  logic [N_SYM*SYM_BITS-1:0] pkt_dta,
  input  logic                      pkt_new,
  input  logic [ERR_BITS-1:0]       pkt_errors,
  output logic [63:0]               m_axis_tdata,
  output logic [7:0]                m_axis_tkeep,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tvalid,
  output logic                      pkt_drop,
  output logic [CNT_BITS-1:0]       drop_cnt,
  output logic                      busy
);

  localparam int DW = N_SYM * SYM_BITS;

  typedef enum logic [1:0] {
    IDLE, BEAT0, BEAT1, BEAT2
  } state_t;

  typedef struct packed {
    logic [DW-1:0]       dta;
    logic                nw;
    logic [ERR_BITS-1:0] err;
  } slot_t;

  function automatic logic [7:0] sym(
    input logic [DW-1:0] d,
    input int            i
  );
    logic [7:0] b;
    b = '0;
    b[SYM_BITS-1:0] = d[i*SYM_BITS +: SYM_BITS];
    return b;
  endfunction

  state_t state_q, state_d;
  slot_t  act_q, act_d;
  slot_t  pnd_q, pnd_d;
  slot_t  in_s;
  logic   pnd_vld_q, pnd_vld_d;
  logic   drop_d;
  logic   hs, last_hs;

  logic [63:0] tdata_d;
  logic [7:0]  tkeep_d;
  logic        tlast_d;

  assign in_s    = {pkt_dta, pkt_new, pkt_errors};
  assign hs      = m_axis_tvalid && m_axis_tready;
  assign last_hs = hs && (state_q == BEAT2);

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q   <= IDLE;
      act_q     <= '0;
      pnd_q     <= '0;
      pnd_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      pnd_q     <= pnd_d;
      pnd_vld_q <= pnd_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pkt_vld) state_d = BEAT0;
      BEAT0: if (hs) state_d = BEAT1;
      BEAT1: if (hs) state_d = BEAT2;
      BEAT2: begin
        if (hs) begin
          state_d = (pnd_vld_q || pkt_vld) ? BEAT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot bookkeeping. The active slot only changes when idle or on the
  // final handshake, so beat contents hold still across stalls.
  always_comb begin
    act_d     = act_q;
    pnd_d     = pnd_q;
    pnd_vld_d = pnd_vld_q;
    drop_d    = 1'b0;
    if (state_q == IDLE) begin
      if (pkt_vld) act_d = in_s;
    end else if (last_hs) begin
      if (pnd_vld_q) begin
        act_d     = pnd_q;
        pnd_vld_d = pkt_vld;
        if (pkt_vld) pnd_d = in_s;
      end else if (pkt_vld) begin
        act_d = in_s;
      end
    end else if (pkt_vld) begin
      if (!pnd_vld_q) begin
        pnd_vld_d = 1'b1;
        pnd_d     = in_s;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // Beat contents are built from next state/slot and then registered.
  always_comb begin
    tdata_d = '0;
    tkeep_d = '0;
    tlast_d = 1'b0;
    unique case (state_d)
      BEAT0: begin
        for (int k = 0; k < 8; k++)
          tdata_d[8*k +: 8] = sym(act_d.dta, k);
        tkeep_d = 8'hFF;
      end
      BEAT1: begin
        for (int k = 0; k < 8; k++)
          tdata_d[8*k +: 8] = sym(act_d.dta, k + 8);
        tkeep_d = 8'hFF;
      end
      BEAT2: begin
        for (int k = 0; k < 5; k++)
          tdata_d[8*k +: 8] = sym(act_d.dta, k + 16);
        tdata_d[40 +: ERR_BITS] = act_d.err;
        tdata_d[48]             = act_d.nw;
        tkeep_d = 8'h7F;
        tlast_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_drop      <= 1'b0;
      drop_cnt      <= '0;
      busy          <= 1'b0;
    end else begin
      m_axis_tvalid <= (state_d != IDLE);
      m_axis_tdata  <= tdata_d;
      m_axis_tkeep  <= tkeep_d;
      m_axis_tlast  <= tlast_d;
      pkt_drop      <= drop_d;
      busy          <= (state_d != IDLE) || pnd_vld_d;
      if (drop_d && (drop_cnt != {CNT_BITS{1'b1}}))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rs_result_axis_packer.sv
// tb_rs_result_axis_packer: directed self-checking bench for
// rs_result_axis_packer (beats, stalls, overflow, reset).
module tb_rs_result_axis_packer;

  logic         m_axis_aclk = 1'b0;
  logic         m_axis_aresetn = 1'b0;
  logic         pkt_vld = 1'b0;
  logic [104:0] pkt_dta = '0;
  logic         pkt_new = 1'b0;
  logic [2:0]   pkt_errors = '0;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tvalid;
  logic         pkt_drop;
  logic [7:0]   drop_cnt;
  logic         busy;

  rs_result_axis_packer dut (
    .m_axis_aclk   (m_axis_aclk),
    .m_axis_aresetn(m_axis_aresetn),
    .pkt_vld       (pkt_vld),
    .pkt_dta       (pkt_dta),
    .pkt_new       (pkt_new),
    .pkt_errors    (pkt_errors),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .pkt_drop      (pkt_drop),
    .drop_cnt      (drop_cnt),
    .busy          (busy)
  );

  always #5 m_axis_aclk = ~m_axis_aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] bd[$];
  logic [7:0]  bk[$];
  logic        bl[$];
  int          bc[$];
  int          drops;
  int          stab_viol;
  int          stalls;
  bit          prev_stall;
  logic [72:0] prev_out;

  function automatic logic [104:0] seq_dta();
    logic [104:0] r;
    r = '0;
    for (int i = 1; i <= 21; i++) r[5*i-5 +: 5] = 5'(i);
    return r;
  endfunction

  function automatic logic [104:0] uni(input logic [4:0] v);
    return {21{v}};
  endfunction

  function automatic logic [63:0] eb(
    input logic [4:0] v,
    input logic [2:0] e,
    input logic       n,
    input int         b
  );
    logic [7:0] s;
    s = {3'b000, v};
    if (b < 2) return {8{s}};
    return {8'h00, 7'd0, n, 5'd0, e, {5{s}}};
  endfunction

  // One cycle: observe at the falling edge, then drive the next inputs.
  task automatic step(
    input bit           rdy,
    input bit           vld,
    input logic [104:0] d,
    input logic [2:0]   e,
    input bit           n
  );
    @(negedge m_axis_aclk);
    cyc++;
    if (prev_stall) begin
      if (!m_axis_tvalid ||
          {m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== prev_out)
        stab_viol++;
    end
    if (pkt_drop) drops++;
    if (m_axis_tvalid && rdy) begin
      bd.push_back(m_axis_tdata);
      bk.push_back(m_axis_tkeep);
      bl.push_back(m_axis_tlast);
      bc.push_back(cyc);
    end
    prev_stall = m_axis_tvalid && !rdy;
    if (prev_stall) stalls++;
    prev_out = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    m_axis_tready = rdy;
    pkt_vld       = vld;
    pkt_dta       = d;
    pkt_errors    = e;
    pkt_new       = n;
  endtask

  task automatic idle(input bit rdy);
    step(rdy, 1'b0, '0, 3'd0, 1'b0);
  endtask

  task automatic clear_log();
    bd.delete(); bk.delete(); bl.delete(); bc.delete();
    drops = 0; stab_viol = 0; stalls = 0; prev_stall = 0;
  endtask

  task automatic do_reset();
    m_axis_aresetn = 1'b0;
    pkt_vld = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge m_axis_aclk);
    m_axis_aresetn = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_async_tvalid: got %b want 0", m_axis_tvalid);
    end
    do_reset();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid);
    end
    checks++;
    if (m_axis_tdata !== 64'd0) begin
      errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata);
    end
    checks++;
    if (m_axis_tkeep !== 8'd0) begin
      errors++; $display("FAIL reset_tkeep: got %h want 0", m_axis_tkeep);
    end
    checks++;
    if (m_axis_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast);
    end
    checks++;
    if (pkt_drop !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_drop: got %b/%0d want 0/0", pkt_drop, drop_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    logic [63:0] ed[3];
    logic [7:0]  ek[3];
    int c0;
    ed[0] = 64'h0807060504030201;
    ed[1] = 64'h100F0E0D0C0B0A09;
    ed[2] = 64'h0001021514131211;
    ek[0] = 8'hFF; ek[1] = 8'hFF; ek[2] = 8'h7F;
    do_reset();
    step(1'b1, 1'b1, seq_dta(), 3'd2, 1'b1);
    c0 = cyc;
    repeat (5) idle(1'b1);
    checks++;
    if (bd.size() != 3) begin
      errors++; $display("FAIL single_count: got %0d want 3", bd.size());
    end
    for (int i = 0; i < bd.size() && i < 3; i++) begin
      checks++;
      if (bd[i] !== ed[i] || bk[i] !== ek[i] || bl[i] !== (i == 2)) begin
        errors++;
        $display("FAIL single_beat%0d: got %h/%h/%b want %h/%h/%b",
                 i, bd[i], bk[i], bl[i], ed[i], ek[i], i == 2);
      end
    end
    if (bc.size() == 3) begin
      checks++;
      if (bc[0] != c0 + 1 || bc[2] != c0 + 3) begin
        errors++;
        $display("FAIL single_timing: got %0d..%0d want %0d..%0d",
                 bc[0] - c0, bc[2] - c0, 1, 3);
      end
    end
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got %b/%b want 0/0", m_axis_tvalid, busy);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b1, 1'b1, seq_dta(), 3'd2, 1'b1);
    for (int i = 0; i < 12; i++) idle(i % 2 == 0);
    checks++;
    if (bd.size() != 3) begin
      errors++; $display("FAIL stall_count: got %0d want 3", bd.size());
    end
    if (bd.size() == 3) begin
      checks++;
      if (bd[0] !== 64'h0807060504030201 ||
          bd[1] !== 64'h100F0E0D0C0B0A09 ||
          bd[2] !== 64'h0001021514131211) begin
        errors++;
        $display("FAIL stall_data: got %h %h %h want %h %h %h",
                 bd[0], bd[1], bd[2], 64'h0807060504030201,
                 64'h100F0E0D0C0B0A09, 64'h0001021514131211);
      end
    end
    checks++;
    if (stab_viol != 0 || stalls < 2) begin
      errors++;
      $display("FAIL stall_hold: got %0d violations %0d stalls want 0 and >=2",
               stab_viol, stalls);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] v;
    logic [2:0] e;
    logic       n;
    do_reset();
    step(1'b0, 1'b1, uni(5'd3), 3'd1, 1'b0);
    step(1'b0, 1'b1, uni(5'd7), 3'd2, 1'b1);
    step(1'b0, 1'b1, uni(5'd9), 3'd3, 1'b0);
    idle(1'b0);
    checks++;
    if (pkt_drop !== 1'b1 || drop_cnt !== 8'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: got %b/%0d/%b want 1/1/1", pkt_drop, drop_cnt, busy);
    end
    repeat (12) idle(1'b1);
    checks++;
    if (bd.size() != 6) begin
      errors++; $display("FAIL ovf_count: got %0d want 6", bd.size());
    end
    for (int i = 0; i < bd.size() && i < 6; i++) begin
      v = (i < 3) ? 5'd3 : 5'd7;
      e = (i < 3) ? 3'd1 : 3'd2;
      n = (i >= 3);
      checks++;
      if (bd[i] !== eb(v, e, n, i % 3) || bl[i] !== (i % 3 == 2) ||
          bk[i] !== ((i % 3 == 2) ? 8'h7F : 8'hFF)) begin
        errors++;
        $display("FAIL ovf_beat%0d: got %h/%h/%b want %h/%h/%b", i, bd[i], bk[i],
                 bl[i], eb(v, e, n, i % 3), (i % 3 == 2) ? 8'h7F : 8'hFF, i % 3 == 2);
      end
    end
    checks++;
    if (drops != 1 || drop_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_end: got %0d/%0d/%b want 1/1/0", drops, drop_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] vs[3];
    logic [2:0] es[3];
    logic       ns[3];
    vs[0] = 5'd1; vs[1] = 5'd2; vs[2] = 5'd4;
    es[0] = 3'd0; es[1] = 3'd1; es[2] = 3'd5;
    ns[0] = 1'b0; ns[1] = 1'b1; ns[2] = 1'b1;
    do_reset();
    step(1'b1, 1'b1, uni(vs[0]), es[0], ns[0]);
    step(1'b1, 1'b1, uni(vs[1]), es[1], ns[1]);
    idle(1'b1);
    step(1'b1, 1'b1, uni(vs[2]), es[2], ns[2]);
    repeat (12) idle(1'b1);
    checks++;
    if (bd.size() != 9) begin
      errors++; $display("FAIL b2b_count: got %0d want 9", bd.size());
    end
    if (bd.size() == 9) begin
      checks++;
      if (bc[8] - bc[0] != 8) begin
        errors++; $display("FAIL b2b_gap: got span %0d want 8", bc[8] - bc[0]);
      end
    end
    for (int i = 0; i < bd.size() && i < 9; i++) begin
      checks++;
      if (bd[i] !== eb(vs[i/3], es[i/3], ns[i/3], i % 3) ||
          bl[i] !== (i % 3 == 2)) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, bd[i], bl[i],
                 eb(vs[i/3], es[i/3], ns[i/3], i % 3), i % 3 == 2);
      end
    end
    checks++;
    if (drops != 0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL b2b_drop: got %0d/%0d want 0/0", drops, drop_cnt);
    end
  endtask

  task automatic test_saturate();
    int   wraps;
    logic [7:0] last;
    wraps = 0;
    last = 8'd0;
    do_reset();
    for (int i = 0; i < 302; i++) begin
      step(1'b0, 1'b1, uni(5'd5), 3'd0, 1'b0);
      if (drop_cnt < last) wraps++;
      last = drop_cnt;
    end
    idle(1'b0);
    idle(1'b0);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_cnt: got %0d want 255", drop_cnt);
    end
    checks++;
    if (wraps != 0) begin
      errors++; $display("FAIL sat_wrap: got %0d wraps want 0", wraps);
    end
    checks++;
    if (drops != 300) begin
      errors++; $display("FAIL sat_pulses: got %0d want 300", drops);
    end
  endtask

  task automatic test_reset_mid();
    int nlast;
    do_reset();
    step(1'b1, 1'b1, uni(5'd6), 3'd1, 1'b0);
    idle(1'b1);
    @(posedge m_axis_aclk);
    #2;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== eb(5'd6, 3'd1, 1'b0, 1)) begin
      errors++;
      $display("FAIL rmid_beat1: got %b/%h want 1/%h", m_axis_tvalid,
               m_axis_tdata, eb(5'd6, 3'd1, 1'b0, 1));
    end
    m_axis_aresetn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'd0 ||
        m_axis_tkeep !== 8'd0 || m_axis_tlast !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got %b/%h/%h/%b/%b want all 0", m_axis_tvalid,
               m_axis_tdata, m_axis_tkeep, m_axis_tlast, busy);
    end
    @(negedge m_axis_aclk);
    m_axis_aresetn = 1'b1;
    clear_log();
    step(1'b1, 1'b1, uni(5'd11), 3'd4, 1'b1);
    repeat (6) idle(1'b1);
    checks++;
    if (bd.size() != 3) begin
      errors++; $display("FAIL rmid_count: got %0d want 3", bd.size());
    end
    if (bd.size() == 3) begin
      checks++;
      if (bd[0] !== eb(5'd11, 3'd4, 1'b1, 0) ||
          bd[2] !== eb(5'd11, 3'd4, 1'b1, 2)) begin
        errors++;
        $display("FAIL rmid_data: got %h/%h want %h/%h", bd[0], bd[2],
                 eb(5'd11, 3'd4, 1'b1, 0), eb(5'd11, 3'd4, 1'b1, 2));
      end
    end
    nlast = 0;
    foreach (bl[i]) if (bl[i]) nlast++;
    checks++;
    if (nlast != 1) begin
      errors++; $display("FAIL rmid_tlast: got %0d tlast beats want 1", nlast);
    end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
